bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin IDLE->GRANT->BUSY->RELEASE, all outputs registered, grant 1 cycle after the request
// is sampled; BUSY ends on the selected slave's done, owner req drop or TIMEOUT, with one RELEASE cycle before re-arbitration.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_rw,
    input  logic       m2_rw,
    input  logic [1:0] m1_slave_sel,
    input  logic [1:0] m2_slave_sel,
    input  logic [2:0] s_rx_done,
    input  logic [2:0] s_tx_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       mst_sel,
    output logic [2:0] slave_en,
    output logic       bus_busy,
    output logic       timeout_err,
    output logic       sel_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_RELEASE} state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic       r_owner, r_rw, r_last;
    logic [1:0] r_sel;
    logic [7:0] r_cnt;

    logic       r_m1_grant, r_m2_grant, r_mst_sel, r_bus_busy, r_timeout_err, r_sel_err;
    logic [2:0] r_slave_en;
    logic       w_m1_grant_nxt, w_m2_grant_nxt, w_mst_sel_nxt, w_bus_busy_nxt;
    logic       w_timeout_err_nxt, w_sel_err_nxt;
    logic [2:0] w_slave_en_nxt;

    logic       w_m1_vld, w_m2_vld, w_any_vld, w_pick_m2, w_pick_rw;
    logic [1:0] w_pick_sel;
    logic       w_owner_req, w_done, w_tmo, w_rel;

    assign w_m1_vld    = m1_req && (m1_slave_sel != 2'd3);
    assign w_m2_vld    = m2_req && (m2_slave_sel != 2'd3);
    assign w_any_vld   = w_m1_vld || w_m2_vld;
    // r_last = 1 means master 2 owned the bus last, so master 1 wins a tie
    assign w_pick_m2   = w_m2_vld && (!w_m1_vld || !r_last);
    assign w_pick_sel  = w_pick_m2 ? m2_slave_sel : m1_slave_sel;
    assign w_pick_rw   = w_pick_m2 ? m2_rw : m1_rw;
    assign w_owner_req = r_owner ? m2_req : m1_req;
    assign w_done      = r_rw ? s_tx_done[r_sel] : s_rx_done[r_sel];
    assign w_tmo       = (r_cnt == LP_CNT_LAST);
    assign w_rel       = w_done || !w_owner_req || w_tmo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_rw          <= 1'b0;
            r_sel         <= 2'd0;
            r_last        <= 1'b1;
            r_cnt         <= 8'd0;
            r_m1_grant    <= 1'b0;
            r_m2_grant    <= 1'b0;
            r_mst_sel     <= 1'b0;
            r_slave_en    <= 3'b000;
            r_bus_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_vld) begin
                r_owner <= w_pick_m2;
                r_rw    <= w_pick_rw;
                r_sel   <= w_pick_sel;
            end
            if (r_state == ST_GRANT) begin
                r_cnt <= 8'd0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == ST_RELEASE) begin
                r_last <= r_owner;
            end
            r_m1_grant    <= w_m1_grant_nxt;
            r_m2_grant    <= w_m2_grant_nxt;
            r_mst_sel     <= w_mst_sel_nxt;
            r_slave_en    <= w_slave_en_nxt;
            r_bus_busy    <= w_bus_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_sel_err     <= w_sel_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_any_vld) w_state_nxt = ST_GRANT;
            ST_GRANT:   w_state_nxt = ST_BUSY;
            ST_BUSY:    if (w_rel) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_m1_grant_nxt    = 1'b0;
        w_m2_grant_nxt    = 1'b0;
        w_mst_sel_nxt     = r_mst_sel;
        w_slave_en_nxt    = 3'b000;
        w_bus_busy_nxt    = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_sel_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel_err_nxt = (m1_req && m1_slave_sel == 2'd3) ||
                                (m2_req && m2_slave_sel == 2'd3);
                if (w_any_vld) begin
                    w_m1_grant_nxt = !w_pick_m2;
                    w_m2_grant_nxt = w_pick_m2;
                    w_mst_sel_nxt  = w_pick_m2;
                    w_slave_en_nxt = 3'b001 << w_pick_sel;
                    w_bus_busy_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                w_m1_grant_nxt = r_m1_grant;
                w_m2_grant_nxt = r_m2_grant;
                w_slave_en_nxt = r_slave_en;
                w_bus_busy_nxt = 1'b1;
            end
            ST_BUSY: begin
                if (w_rel) begin
                    w_timeout_err_nxt = !w_done && w_owner_req && w_tmo;
                end else begin
                    w_m1_grant_nxt = r_m1_grant;
                    w_m2_grant_nxt = r_m2_grant;
                    w_slave_en_nxt = r_slave_en;
                    w_bus_busy_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign m1_grant    = r_m1_grant;
    assign m2_grant    = r_m2_grant;
    assign mst_sel     = r_mst_sel;
    assign slave_en    = r_slave_en;
    assign bus_busy    = r_bus_busy;
    assign timeout_err = r_timeout_err;
    assign sel_err     = r_sel_err;
endmodule
